// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide unit for the Execute stage: one bit per cycle,
// stalls the pipeline while busy and reports ALU-format ZNCV condition codes.
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_Start,
   input  logic [3:0]       i_ALU_Ctrl,
   input  logic [WIDTH-1:0] i_Op1,
   input  logic [WIDTH-1:0] i_Op2,
   input  logic             i_Flush,
   output logic             o_Stall,
   output logic             o_Valid,
   output logic [WIDTH-1:0] o_Rslt,
   output logic [WIDTH-1:0] o_Aux,
   output logic [3:0]       o_CCodes
);

   localparam logic [3:0]       OP_MUL   = 4'b0111;
   localparam logic [3:0]       OP_DIV   = 4'b1000;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             op_div;
   logic [WIDTH-1:0] opnd;
   logic [WIDTH-1:0] acc_hi;
   logic [WIDTH-1:0] acc_lo;

   logic             is_mul, is_div, start_ok, div_zero;
   logic [WIDTH:0]   mul_sum, div_shift, div_diff;
   logic [WIDTH-1:0] nxt_hi, nxt_lo;

   // Condition codes in ALU bit order: {V, C, N, Z}
   function automatic logic [3:0] cc_calc(input logic [WIDTH-1:0] rslt,
                                          input logic [WIDTH-1:0] aux,
                                          input logic             ovf);
      return {ovf, |aux, rslt[WIDTH-1], (rslt == '0)};
   endfunction

   always_comb begin
      is_mul   = (i_ALU_Ctrl == OP_MUL);
      is_div   = (i_ALU_Ctrl == OP_DIV);
      start_ok = i_Start & ~i_Flush & (is_mul | is_div);
      div_zero = is_div & (i_Op2 == '0);
      o_Stall  = ((state == S_IDLE) & start_ok) | (state == S_BUSY);
   end

   // acc_hi/acc_lo hold {product_hi, multiplier} for MUL and {remainder, quotient} for DIV
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = div_shift - {1'b0, opnd};
      nxt_hi    = mul_sum[WIDTH:1];
      nxt_lo    = {mul_sum[0], acc_lo[WIDTH-1:1]};
      if (op_div) begin
         // Shifted remainder is below twice the divisor, so bit WIDTH of the difference is its sign
         if (!div_diff[WIDTH]) begin
            nxt_hi = div_diff[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
         end else begin
            nxt_hi = div_shift[WIDTH-1:0];
            nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         o_Valid  <= 1'b0;
         o_Rslt   <= '0;
         o_Aux    <= '0;
         o_CCodes <= '0;
      end else begin
         o_Valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_ok) begin
                  if (div_zero) begin
                     state    <= S_DONE;
                     o_Valid  <= 1'b1;
                     o_Rslt   <= '1;
                     o_Aux    <= i_Op1;
                     o_CCodes <= cc_calc('1, i_Op1, 1'b1);
                  end else begin
                     state  <= S_BUSY;
                     cnt    <= '0;
                     op_div <= is_div;
                     opnd   <= is_div ? i_Op2 : i_Op1;
                     acc_hi <= '0;
                     acc_lo <= is_div ? i_Op1 : i_Op2;
                  end
               end
            end
            S_BUSY: begin
               if (i_Flush) begin
                  state <= S_IDLE;
               end else begin
                  acc_hi <= nxt_hi;
                  acc_lo <= nxt_lo;
                  if (cnt == LAST_CNT) begin
                     state    <= S_DONE;
                     o_Valid  <= 1'b1;
                     o_Rslt   <= nxt_lo;
                     o_Aux    <= nxt_hi;
                     o_CCodes <= cc_calc(nxt_lo, nxt_hi, 1'b0);
                  end else begin
                     cnt <= cnt + CNT_W'(1);
                  end
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: table of MUL/DIV vectors plus flush and reset sequences.
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_Start;
   logic [3:0]  i_ALU_Ctrl;
   logic [31:0] i_Op1, i_Op2;
   logic        i_Flush;
   logic        o_Stall, o_Valid;
   logic [31:0] o_Rslt, o_Aux;
   logic [3:0]  o_CCodes;

   int n_cmp  = 0;
   int n_fail = 0;

   localparam logic [3:0] MUL = 4'b0111;
   localparam logic [3:0] DIV = 4'b1000;
   localparam logic [3:0] ADD = 4'b0010;

   muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .clk(clk), .reset(reset), .i_Start(i_Start), .i_ALU_Ctrl(i_ALU_Ctrl),
      .i_Op1(i_Op1), .i_Op2(i_Op2), .i_Flush(i_Flush), .o_Stall(o_Stall),
      .o_Valid(o_Valid), .o_Rslt(o_Rslt), .o_Aux(o_Aux), .o_CCodes(o_CCodes)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] rslt;
      logic [31:0] aux;
      logic [3:0]  cc;
      int          lat;
   } vec_t;

   vec_t vecs[11];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int lat;
      bit stall_ok;
      i_ALU_Ctrl = v.ctrl;
      i_Op1      = v.a;
      i_Op2      = v.b;
      i_Start    = 1'b1;
      #1;
      lat      = 0;
      stall_ok = 1'b1;
      while (!o_Valid && lat < 100) begin
         if (!o_Stall) stall_ok = 1'b0;
         tick();
         i_Start    = 1'b0;
         i_ALU_Ctrl = ADD;
         i_Op1      = 32'hDEAD_BEEF;
         i_Op2      = 32'h0000_0000;
         #1;
         lat++;
      end
      chk({name, " latency"}, 64'(lat), 64'(v.lat));
      chk({name, " stall while busy"}, 64'(stall_ok), 64'd1);
      chk({name, " stall in done"}, 64'(o_Stall), 64'd0);
      chk({name, " rslt"}, 64'(o_Rslt), 64'(v.rslt));
      chk({name, " aux"}, 64'(o_Aux), 64'(v.aux));
      chk({name, " ccodes"}, 64'(o_CCodes), 64'(v.cc));
      tick();
      chk({name, " valid one cycle"}, 64'(o_Valid), 64'd0);
      chk({name, " rslt held"}, 64'(o_Rslt), 64'(v.rslt));
   endtask

   initial begin
      int  seen;
      bit  stall_seen;
      vecs[0]  = '{MUL, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A, 32'h0000_0000, 4'b0000, 33};
      vecs[1]  = '{MUL, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001, 4'b0110, 33};
      vecs[2]  = '{DIV, 32'd100,       32'd7,         32'd14,        32'd2,         4'b0100, 33};
      vecs[3]  = '{DIV, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000, 4'b0010, 33};
      vecs[4]  = '{DIV, 32'd5,         32'd0,         32'hFFFF_FFFF, 32'd5,         4'b1110, 1};
      vecs[5]  = '{MUL, 32'h0000_0000, 32'h0001_2345, 32'h0000_0000, 32'h0000_0000, 4'b0001, 33};
      vecs[6]  = '{MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE, 4'b0100, 33};
      vecs[7]  = '{DIV, 32'd7,         32'd100,       32'd0,         32'd7,         4'b0101, 33};
      vecs[8]  = '{DIV, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 4'b0000, 33};
      vecs[9]  = '{DIV, 32'hFFFF_FFFF, 32'h0000_0010, 32'h0FFF_FFFF, 32'h0000_000F, 4'b0100, 33};
      vecs[10] = '{MUL, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001, 4'b0101, 33};

      reset = 1'b1; i_Start = 1'b0; i_ALU_Ctrl = 4'b0000;
      i_Op1 = '0; i_Op2 = '0; i_Flush = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      #1;
      chk("reset valid",  64'(o_Valid),  64'd0);
      chk("reset stall",  64'(o_Stall),  64'd0);
      chk("reset rslt",   64'(o_Rslt),   64'd0);
      chk("reset aux",    64'(o_Aux),    64'd0);
      chk("reset ccodes", 64'(o_CCodes), 64'd0);

      for (int i = 0; i < 11; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Flush at BUSY cycle 10: no result, outputs keep the last vector's values
      i_ALU_Ctrl = MUL; i_Op1 = 32'h0000_1234; i_Op2 = 32'h0000_5678; i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      repeat (9) tick();
      i_Flush = 1'b1;
      #1;
      chk("flush stall same cycle", 64'(o_Stall), 64'd1);
      tick();
      i_Flush = 1'b0;
      #1;
      chk("flush stall next", 64'(o_Stall), 64'd0);
      seen = 0;
      for (int c = 0; c < 40; c++) begin
         if (o_Valid) seen++;
         tick();
      end
      chk("flush no valid", 64'(seen), 64'd0);
      chk("flush rslt kept", 64'(o_Rslt), 64'(vecs[10].rslt));
      chk("flush aux kept", 64'(o_Aux), 64'(vecs[10].aux));
      run_vec('{MUL, 32'd3, 32'd3, 32'd9, 32'd0, 4'b0000, 33}, "mul after flush");

      // Flush in IDLE beats a start in the same cycle
      i_ALU_Ctrl = DIV; i_Op1 = 32'd50; i_Op2 = 32'd5; i_Start = 1'b1; i_Flush = 1'b1;
      #1;
      chk("idle flush stall", 64'(o_Stall), 64'd0);
      tick();
      i_Start = 1'b0; i_Flush = 1'b0;
      #1;
      seen = 0; stall_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (o_Valid) seen++;
         if (o_Stall) stall_seen = 1'b1;
         tick();
      end
      chk("idle flush no valid", 64'(seen), 64'd0);
      chk("idle flush no stall", 64'(stall_seen), 64'd0);

      // Reset in the middle of BUSY clears everything
      i_ALU_Ctrl = MUL; i_Op1 = 32'd7; i_Op2 = 32'd6; i_Start = 1'b1;
      tick();
      i_Start = 1'b0;
      repeat (5) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("midreset valid",  64'(o_Valid),  64'd0);
      chk("midreset stall",  64'(o_Stall),  64'd0);
      chk("midreset rslt",   64'(o_Rslt),   64'd0);
      chk("midreset aux",    64'(o_Aux),    64'd0);
      chk("midreset ccodes", 64'(o_CCodes), 64'd0);

      // Start with a non-MUL/DIV code is ignored
      i_ALU_Ctrl = ADD; i_Op1 = 32'd1; i_Op2 = 32'd2; i_Start = 1'b1;
      #1;
      chk("add start stall", 64'(o_Stall), 64'd0);
      seen = 0; stall_seen = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (o_Valid) seen++;
         if (o_Stall) stall_seen = 1'b1;
         tick();
      end
      i_Start = 1'b0;
      chk("add no valid", 64'(seen), 64'd0);
      chk("add no stall", 64'(stall_seen), 64'd0);
      chk("add rslt zero", 64'(o_Rslt), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
